// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity constants and divider sizing
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period clock enable, one tick every DIV enabled cycles
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = div_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - valid/ready UART transmitter, configurable data/stop bits
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 12000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BIW = $clog2(DATA_BITS);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PARITY_NONE);
  logic par_q, par_d;
  logic par_calc;
  assign par_calc = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
`else
  // PARITY_MODE has no effect in this build; frames are always N
  localparam bit PAR_ON = 1'b0 && (PARITY_MODE != PARITY_NONE);
`endif

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIW-1:0]       bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  assign tx_ready = (state_q == IDLE);
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign tx       = tx_q;
  assign done     = done_q;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk  (clk),
    .nrst (nrst),
    .en   (busy),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = tx_data;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = START;
`ifdef UART_TX_PARITY_EN
          par_d      = par_calc;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = PAR_ON ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so tx is a plain flop with no decode glitches
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - randomized frame checks of uart_tx_core against a bit-period model
module tb_uart_tx_core;

  logic       clk;
  logic       nrst;
  logic [8:0] tx_data [4];
  logic [3:0] tx_valid;
  wire  [3:0] tx_w, rdy_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1   1: 5 data / 2 stop   2: 7 data even   3: 7 data odd; all DIV = 10
  uart_tx_core #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0)) dut0 (
    .clk(clk), .nrst(nrst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_core #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(5), .STOP_BITS(2), .PARITY_MODE(0)) dut1 (
    .clk(clk), .nrst(nrst), .tx_data(tx_data[1][4:0]), .tx_valid(tx_valid[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_core #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(1), .PARITY_MODE(1)) dut2 (
    .clk(clk), .nrst(nrst), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_core #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(1), .PARITY_MODE(2)) dut3 (
    .clk(clk), .nrst(nrst), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int cfg_nb(input int i);
    case (i)
      0: return 8;
      1: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int cfg_pm(input int i);
`ifdef UART_TX_PARITY_EN
    return (i == 2) ? 1 : (i == 3) ? 2 : 0;
`else
    return (i < 0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [8:0] mask(input int i);
    return 9'((1 << cfg_nb(i)) - 1);
  endfunction

  function automatic int frame_len(input int i);
    return 10 * (1 + cfg_nb(i) + ((cfg_pm(i) != 0) ? 1 : 0) + cfg_sb(i));
  endfunction

  // Expected line level k cycles after the accept edge, one bit every 10 cycles
  function automatic logic exp_bit(input int i, input logic [8:0] d, input int k);
    int b;
    int ones;
    b = k / 10;
    if (b == 0) return 1'b0;
    if (b <= cfg_nb(i)) return d[b-1];
    if (cfg_pm(i) != 0 && b == cfg_nb(i) + 1) begin
      ones = 0;
      for (int j = 0; j < cfg_nb(i); j++) ones += int'(d[j]);
      return (cfg_pm(i) == 1) ? 1'((ones % 2) == 1) : 1'((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  // Called right after the accept edge; samples every cycle through the done cycle
  task automatic run_frame(input int i, input logic [8:0] d, input bit hold, input logic [8:0] nd);
    int L;
    logic [3:0] got, exp;
    L = frame_len(i);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      got = {tx_w[i], rdy_w[i], busy_w[i], done_w[i]};
      exp = (k < L) ? {exp_bit(i, d, k), 3'b010} : 4'b1101;
      check($sformatf("frm%0d_d%0h_k%0d", i, d, k), 32'(got), 32'(exp));
      if (k == 0) begin
        tx_data[i]  = 9'($urandom);
        tx_valid[i] = hold;
      end
      if (k == L && hold) tx_data[i] = nd;
    end
  endtask

  task automatic send(input int i, input logic [8:0] d, input bit hold, input logic [8:0] nd);
    @(negedge clk);
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    @(posedge clk);
    run_frame(i, d, hold, nd);
    if (hold) begin
      @(posedge clk);
      run_frame(i, nd, 1'b0, 9'h0);
    end
  endtask

  initial begin
    logic [8:0] d, nd;
    bit         bb;

    nrst     = 1'b0;
    tx_valid = 4'b0001;
    for (int i = 0; i < 4; i++) tx_data[i] = 9'h0;
    tx_data[0] = 9'h061;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        check($sformatf("rst%0d", i), 32'({tx_w[i], rdy_w[i], busy_w[i], done_w[i]}), 32'(4'b1100));
    end
    nrst = 1'b1;
    @(posedge clk);
    run_frame(0, 9'h061, 1'b0, 9'h0);

    send(0, 9'h053, 1'b1, 9'h070);
    send(2, 9'h06E, 1'b0, 9'h0);
    send(3, 9'h06E, 1'b0, 9'h0);
    send(1, 9'h01F, 1'b0, 9'h0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) begin
        d  = 9'($urandom) & mask(i);
        nd = 9'($urandom) & mask(i);
        bb = 1'($urandom_range(0, 1));
        send(i, d, bb, nd);
      end
    end

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0, so the line must jump high)
    @(negedge clk);
    tx_data[0]  = 9'h0A5;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tx_data[0]  = 9'h0;
    repeat (45) @(negedge clk);
    check("pre_rst_tx", 32'(tx_w[0]), 32'(exp_bit(0, 9'h0A5, 45)));
    nrst = 1'b0;
    #1;
    check("mid_rst", 32'({tx_w[0], rdy_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold", 32'({tx_w[0], rdy_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
    end
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst", 32'({tx_w[0], rdy_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
    send(0, 9'h0A5, 1'b0, 9'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
